// File: rtl/cla_pkg.sv
// Shared definitions for the sequenced carry-lookahead adder.
//   CLA_SLICE_W     : width of the reused adder slice
//   cla_seq_state_t : controller states
package cla_pkg;

    localparam int unsigned CLA_SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

endpackage : cla_pkg

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice, purely combinational.
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : slice sum
//   cout : carry out of bit 3
module cla
    import cla_pkg::*;
(
    input  logic [CLA_SLICE_W-1:0] a,
    input  logic [CLA_SLICE_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_SLICE_W-1:0] sum,
    output logic                   cout
);

    logic [CLA_SLICE_W-1:0] g;
    logic [CLA_SLICE_W-1:0] p;
    logic [CLA_SLICE_W:0]   c;

    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[CLA_SLICE_W-1:0];
        cout = c[CLA_SLICE_W];
    end

endmodule : cla

// File: rtl/cla_seq_ctrl.sv
// WIDTH-bit adder built by sequencing one 4-bit CLA slice, LSB nibble first.
//   clk, rst_n               : clock, async active-low reset
//   start_valid/start_ready  : request handshake (a, b, cin sampled at accept)
//   res_valid/res_ready      : result handshake (sum, cout held while valid)
//   busy                     : operation in progress or result pending
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / CLA_SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    cla_seq_state_t   state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             start_ready_q, start_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic [CLA_SLICE_W-1:0] slice_a;
    logic [CLA_SLICE_W-1:0] slice_b;
    logic [CLA_SLICE_W-1:0] slice_sum;
    logic                   slice_cout;
    logic                   last_slice;

    // Operand nibble select for the current slice
    always_comb begin
        slice_a    = a_q[CLA_SLICE_W * 32'(idx_q) +: CLA_SLICE_W];
        slice_b    = b_q[CLA_SLICE_W * 32'(idx_q) +: CLA_SLICE_W];
        last_slice = (idx_q == IDX_W'(NSLICE - 1));
    end

    cla u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[CLA_SLICE_W * 32'(idx_q) +: CLA_SLICE_W] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_slice) begin
                    cout_d  = slice_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags registered alongside the state they decode
        start_ready_d = (state_d == IDLE);
        res_valid_d   = (state_d == DONE);
        busy_d        = (state_d == RUN) || (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            carry_q       <= 1'b0;
            idx_q         <= '0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            carry_q       <= carry_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            cout_q        <= cout_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule : cla_seq_ctrl
